mem_bus_arbiter: RTL and testbench

Sequencer and arbiter for the shared 16-bit memory address / 8-bit data bus. Grants the bus to one of two requesters, the CPU fetch/operand path (port 0) or a DMA/loader port (port 1). For each granted access it drives the memory control strobes for a parameterised number of wait states, then returns read data with a one-cycle acknowledge. It sits between the program-counter/instruction-dispatch logic and the `memory` block, replacing the hard-wired `OE_bar`/`WE_bar` ties.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_wait_counter.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared constants for the memory bus arbiter
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 8;
    localparam int WAIT_W     = 4;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [MEM_ADDR_W-1:0] DEFAULT_RAM_BASE = 16'h8000;

    // Region decode: anything at or above the base is RAM, below is ROM
    function automatic logic is_ram(input logic [MEM_ADDR_W-1:0] addr,
                                    input logic [MEM_ADDR_W-1:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - 4-bit loadable wait-state down-counter
module mem_wait_counter
    import mem_bus_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_bar,
    input  logic              LOAD,
    input  logic              DEC,
    input  logic [WAIT_W-1:0] LOAD_VAL,
    output logic              ZERO
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Load wins over decrement; the counter saturates at zero
    always_comb begin
        count_d = count_q;
        if (LOAD) begin
            count_d = LOAD_VAL;
        end else if (DEC && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign ZERO = (count_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port memory bus arbiter/sequencer (MEM_BUS_ARBITER_CPU_PRIORITY_EN selects fixed CPU priority)
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned            ROM_WAIT = 2,
    parameter int unsigned            RAM_WAIT = 1,
    parameter logic [MEM_ADDR_W-1:0]  RAM_BASE = DEFAULT_RAM_BASE
) (
    input  logic                  CLK,
    input  logic                  RST_bar,
    input  logic [1:0]            REQ,
    input  logic [1:0]            WE,
    input  logic [MEM_ADDR_W-1:0] ADDR0,
    input  logic [MEM_ADDR_W-1:0] ADDR1,
    input  logic [MEM_DATA_W-1:0] WDATA0,
    input  logic [MEM_DATA_W-1:0] WDATA1,
    output logic [1:0]            GNT,
    output logic [1:0]            ACK,
    output logic [MEM_DATA_W-1:0] RDATA,
    output logic [MEM_ADDR_W-1:0] MEM_ADDR,
    output logic [MEM_DATA_W-1:0] MEM_WDATA,
    output logic                  MEM_OE_bar,
    output logic                  MEM_WE_bar,
    input  logic [MEM_DATA_W-1:0] MEM_RDATA
);

    localparam logic [WAIT_W-1:0] ROM_W = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_W = WAIT_W'(RAM_WAIT);

    logic [1:0]            state_q,     state_d;
    logic [1:0]            gnt_q,       gnt_d;
    logic [1:0]            ack_q,       ack_d;
    logic [MEM_DATA_W-1:0] rdata_q,     rdata_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [MEM_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic                  oe_bar_q,    oe_bar_d;
    logic                  we_bar_q,    we_bar_d;
    logic                  lat_we_q,    lat_we_d;
    logic                  lat_ram_q,   lat_ram_d;

    logic                  win_dma;
    logic [MEM_ADDR_W-1:0] win_addr;
    logic                  win_we;
    logic                  win_ram;
    logic [WAIT_W-1:0]     win_wait;
    logic                  start;
    logic                  cnt_zero;

    assign start = (state_q == ST_IDLE) && (REQ != 2'b00);

`ifdef MEM_BUS_ARBITER_CPU_PRIORITY_EN
    // Fixed priority: DMA only gets the bus when the CPU is not asking
    always_comb begin
        win_dma = ~REQ[PORT_CPU];
    end
`else
    logic last_q, last_d;

    // Round-robin: on a tie the port not granted last time wins
    always_comb begin
        if (REQ == 2'b11) begin
            win_dma = ~last_q;
        end else begin
            win_dma = REQ[PORT_DMA];
        end
    end

    // Remember the winner at grant time (1 = DMA)
    always_comb begin
        last_d = last_q;
        if (start) begin
            last_d = win_dma;
        end
    end

    // Pointer resets to DMA so the CPU takes the first tie
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Winner's request fields and its region-dependent wait count
    always_comb begin
        win_addr = win_dma ? ADDR1 : ADDR0;
        win_we   = win_dma ? WE[PORT_DMA] : WE[PORT_CPU];
        win_ram  = is_ram(win_addr, RAM_BASE);
        win_wait = win_ram ? RAM_W : ROM_W;
    end

    mem_wait_counter u_wait (
        .CLK      (CLK),
        .RST_bar  (RST_bar),
        .LOAD     (start),
        .DEC      (state_q == ST_ACCESS),
        .LOAD_VAL (win_wait),
        .ZERO     (cnt_zero)
    );

    // Access sequencer: grant, strobe for W+1 cycles, acknowledge for one
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        oe_bar_d    = oe_bar_q;
        we_bar_d    = we_bar_q;
        lat_we_d    = lat_we_q;
        lat_ram_d   = lat_ram_q;
        case (state_q)
            ST_IDLE: begin
                ack_d    = 2'b00;
                oe_bar_d = 1'b1;
                we_bar_d = 1'b1;
                if (start) begin
                    state_d     = ST_ACCESS;
                    gnt_d       = win_dma ? 2'b10 : 2'b01;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_dma ? WDATA1 : WDATA0;
                    lat_we_d    = win_we;
                    lat_ram_d   = win_ram;
                    // Reads strobe OE from the first cycle; writes hold WE off for address setup
                    oe_bar_d    = win_we;
                end
            end
            ST_ACCESS: begin
                if (cnt_zero) begin
                    state_d  = ST_DONE;
                    ack_d    = gnt_q;
                    oe_bar_d = 1'b1;
                    we_bar_d = 1'b1;
                    if (!lat_we_q) begin
                        rdata_d = MEM_RDATA;
                    end
                end else begin
                    oe_bar_d = lat_we_q;
                    // Writes into the ROM region never strobe WE
                    we_bar_d = ~(lat_we_q & lat_ram_q);
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                gnt_d    = 2'b00;
                ack_d    = 2'b00;
                oe_bar_d = 1'b1;
                we_bar_d = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = 2'b00;
                ack_d    = 2'b00;
                oe_bar_d = 1'b1;
                we_bar_d = 1'b1;
            end
        endcase
    end

    // Sequencer and output registers
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            ack_q       <= 2'b00;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            oe_bar_q    <= 1'b1;
            we_bar_q    <= 1'b1;
            lat_we_q    <= 1'b0;
            lat_ram_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            oe_bar_q    <= oe_bar_d;
            we_bar_q    <= we_bar_d;
            lat_we_q    <= lat_we_d;
            lat_ram_q   <= lat_ram_d;
        end
    end

    assign GNT        = gnt_q;
    assign ACK        = ack_q;
    assign RDATA      = rdata_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign MEM_OE_bar = oe_bar_q;
    assign MEM_WE_bar = we_bar_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        CLK;
    logic        RST_bar;
    logic [1:0]  REQ;
    logic [1:0]  WE;
    logic [15:0] ADDR0;
    logic [15:0] ADDR1;
    logic [7:0]  WDATA0;
    logic [7:0]  WDATA1;
    logic [1:0]  GNT;
    logic [1:0]  ACK;
    logic [7:0]  RDATA;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_OE_bar;
    logic        MEM_WE_bar;
    logic [7:0]  MEM_RDATA;

    int n_checks;
    int n_errors;

    logic [1:0]  gnt_h   [16];
    logic [1:0]  ack_h   [16];
    logic        oe_h    [16];
    logic        we_h    [16];
    logic [7:0]  rdata_h [16];
    logic [15:0] addr_h  [16];
    logic [7:0]  wdata_h [16];

    logic [1:0]  exp_order [4];

    mem_bus_arbiter #(
        .ROM_WAIT (2),
        .RAM_WAIT (1),
        .RAM_BASE (16'h8000)
    ) dut (
        .CLK        (CLK),
        .RST_bar    (RST_bar),
        .REQ        (REQ),
        .WE         (WE),
        .ADDR0      (ADDR0),
        .ADDR1      (ADDR1),
        .WDATA0     (WDATA0),
        .WDATA1     (WDATA1),
        .GNT        (GNT),
        .ACK        (ACK),
        .RDATA      (RDATA),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_OE_bar (MEM_OE_bar),
        .MEM_WE_bar (MEM_WE_bar),
        .MEM_RDATA  (MEM_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record outputs at each falling edge; drop REQ at drop_at, or on ACK when drop_at is 0
    task automatic observe(input int ncyc, input int drop_at);
        for (int i = 0; i < 16; i++) begin
            gnt_h[i] = 2'b00; ack_h[i] = 2'b00; oe_h[i] = 1'b1; we_h[i] = 1'b1;
            rdata_h[i] = 8'h00; addr_h[i] = 16'h0000; wdata_h[i] = 8'h00;
        end
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge CLK);
            gnt_h[i] = GNT; ack_h[i] = ACK; oe_h[i] = MEM_OE_bar; we_h[i] = MEM_WE_bar;
            rdata_h[i] = RDATA; addr_h[i] = MEM_ADDR; wdata_h[i] = MEM_WDATA;
            if ((drop_at == 0 && ACK != 2'b00) || i == drop_at) REQ = 2'b00;
        end
    endtask

    function automatic int first_ack();
        for (int i = 1; i < 16; i++) if (ack_h[i] != 2'b00) return i;
        return 0;
    endfunction

    function automatic int ack_count();
        int n = 0;
        for (int i = 1; i < 16; i++) if (ack_h[i] != 2'b00) n++;
        return n;
    endfunction

    function automatic int oe_low();
        int n = 0;
        for (int i = 1; i < 16; i++) if (!oe_h[i]) n++;
        return n;
    endfunction

    function automatic int we_low();
        int n = 0;
        for (int i = 1; i < 16; i++) if (!we_h[i]) n++;
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] got;
        logic [1:0] a;
        int         k;

        n_checks = 0;
        n_errors = 0;
`ifdef MEM_BUS_ARBITER_CPU_PRIORITY_EN
        exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01; exp_order[3] = 2'b01;
`else
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
`endif
        RST_bar = 1'b0; REQ = 2'b00; WE = 2'b00; ADDR0 = 16'h0; ADDR1 = 16'h0;
        WDATA0 = 8'h0; WDATA1 = 8'h0; MEM_RDATA = 8'h00;
        repeat (2) @(negedge CLK);
        check("rst_gnt",   32'(GNT), 0);
        check("rst_ack",   32'(ACK), 0);
        check("rst_rdata", 32'(RDATA), 0);
        check("rst_addr",  32'(MEM_ADDR), 0);
        check("rst_wdata", 32'(MEM_WDATA), 0);
        check("rst_oe",    32'(MEM_OE_bar), 1);
        check("rst_we",    32'(MEM_WE_bar), 1);
        RST_bar = 1'b1;
        @(negedge CLK);

        // CPU read from ROM, W=2
        REQ = 2'b01; WE = 2'b00; ADDR0 = 16'h0010; MEM_RDATA = 8'hA5;
        observe(6, 0);
        check("t1_gnt",    32'(gnt_h[1]), 1);
        check("t1_addr",   32'(addr_h[1]), 'h0010);
        check("t1_oe_cnt", 32'(oe_low()), 3);
        check("t1_we_cnt", 32'(we_low()), 0);
        check("t1_ack_at", 32'(first_ack()), 4);
        check("t1_ack",    32'(ack_h[4]), 1);
        check("t1_ack_n",  32'(ack_count()), 1);
        check("t1_rdata",  32'(rdata_h[4]), 'hA5);
        check("t1_gnt_dn", 32'(gnt_h[5]), 0);

        // DMA write to RAM, W=1
        REQ = 2'b10; WE = 2'b10; ADDR1 = 16'h8001; WDATA1 = 8'h3C; MEM_RDATA = 8'hEE;
        observe(5, 0);
        check("t2_gnt",    32'(gnt_h[1]), 2);
        check("t2_addr",   32'(addr_h[1]), 'h8001);
        check("t2_wdata",  32'(wdata_h[1]), 'h3C);
        check("t2_we_c1",  32'(we_h[1]), 1);
        check("t2_we_c2",  32'(we_h[2]), 0);
        check("t2_we_cnt", 32'(we_low()), 1);
        check("t2_oe_cnt", 32'(oe_low()), 0);
        check("t2_ack_at", 32'(first_ack()), 3);
        check("t2_ack",    32'(ack_h[3]), 2);
        check("t2_rdata",  32'(rdata_h[3]), 'hA5);
        check("t2_gnt_dn", 32'(gnt_h[4]), 0);

        // Both ports hold REQ for four accesses
        REQ = 2'b11; WE = 2'b00; ADDR0 = 16'h0020; ADDR1 = 16'h9000; MEM_RDATA = 8'h11;
        for (int n = 0; n < 4; n++) begin
            got = 2'b00; k = 0;
            while (got == 2'b00 && k < 12) begin @(negedge CLK); k++; got = GNT; end
            check("t3_grant", 32'(got), 32'(exp_order[n]));
            a = 2'b00; k = 0;
            while (a == 2'b00 && k < 12) begin @(negedge CLK); k++; a = ACK; end
            check("t3_ack", 32'(a), 32'(exp_order[n]));
            if (n == 3) REQ = 2'b00;
        end
        observe(3, -1);
        check("t3_idle1", 32'(gnt_h[1]), 0);
        check("t3_idle3", 32'(gnt_h[3]), 0);

        // DMA write to ROM region: no strobes, still acknowledged
        REQ = 2'b10; WE = 2'b10; ADDR1 = 16'h0100; WDATA1 = 8'h77;
        observe(6, 0);
        check("t4_gnt",    32'(gnt_h[1]), 2);
        check("t4_wdata",  32'(wdata_h[1]), 'h77);
        check("t4_oe_cnt", 32'(oe_low()), 0);
        check("t4_we_cnt", 32'(we_low()), 0);
        check("t4_ack_at", 32'(first_ack()), 4);
        check("t4_ack",    32'(ack_h[4]), 2);
        check("t4_gnt_dn", 32'(gnt_h[5]), 0);

        // CPU drops REQ during the second ACCESS cycle
        REQ = 2'b01; WE = 2'b00; ADDR0 = 16'h0030; MEM_RDATA = 8'h5A;
        observe(7, 2);
        check("t5_ack_at", 32'(first_ack()), 4);
        check("t5_ack",    32'(ack_h[4]), 1);
        check("t5_ack_n",  32'(ack_count()), 1);
        check("t5_rdata",  32'(rdata_h[4]), 'h5A);
        check("t5_gnt5",   32'(gnt_h[5]), 0);
        check("t5_gnt7",   32'(gnt_h[7]), 0);

        // Asynchronous reset in the middle of an access
        REQ = 2'b01; WE = 2'b00; ADDR0 = 16'h0040; WDATA0 = 8'h99; MEM_RDATA = 8'hC3;
        @(negedge CLK);
        check("t6_pre_oe", 32'(MEM_OE_bar), 0);
        #2 RST_bar = 1'b0;
        #1;
        check("t6_gnt",    32'(GNT), 0);
        check("t6_ack",    32'(ACK), 0);
        check("t6_rdata",  32'(RDATA), 0);
        check("t6_addr",   32'(MEM_ADDR), 0);
        check("t6_wdata",  32'(MEM_WDATA), 0);
        check("t6_oe",     32'(MEM_OE_bar), 1);
        check("t6_we",     32'(MEM_WE_bar), 1);
        REQ = 2'b11; ADDR1 = 16'hA000;
        repeat (2) @(negedge CLK);
        RST_bar = 1'b1;
        observe(5, 0);
        check("t6_tie",    32'(gnt_h[1]), 1);
        check("t6_addr2",  32'(addr_h[1]), 'h0040);
        check("t6_ack_at", 32'(first_ack()), 4);
        check("t6_rdata2", 32'(rdata_h[4]), 'hC3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
